st_packer_256_512: RTL and testbench
====================================

# st_packer_256_512

Packs a 256-bit Avalon-ST packet stream into a 512-bit stream, two input beats per output word, with correct SOP/EOP/empty propagation. It sits directly upstream of the 512→256 adapter and is its inverse gearbox: 256-bit ingress traffic is widened for 512-bit processing and later narrowed again. The first input beat of each pair lands in the low half, matching the low-half-first order of the downstream narrowing adapter.

## Interface
Parameters:
- IN_W, 256, input data width (bits)
- OUT_W, 512, output data width; fixed at 2*IN_W
- IN_EW, 5, input empty width (log2 of IN_W/8)
- OUT_EW, 6, output empty width (log2 of OUT_W/8)

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  IN_W  input beat data
- in_startofpacket  in  1  first beat of packet
- in_endofpacket  in  1  last beat of packet
- in_empty  in  IN_EW  unused bytes in the last beat; valid only with EOP
- out_valid  out  1  output word valid
- out_ready  in  1  output word consumed when out_valid && out_ready
- out_data  out  OUT_W  output word; first beat in [IN_W-1:0]
- out_startofpacket  out  1  word holds packet SOP
- out_endofpacket  out  1  word holds packet EOP
- out_empty  out  OUT_EW  unused bytes in the EOP word
- proto_err  out  1  sticky protocol-violation flag; cleared only by reset

## Operation
- Storage: low-half register (lo_data, lo_sop), one output register (out_* fields), and flags in_pkt and rdy_en.
- FSM states:
  - LO: no half held.
  - HI: low half held, waiting for the high half.
- in_ready = rdy_en && (!out_valid || out_ready). The output slot is therefore always free when a beat is accepted.
- Accepted beat in LO:
  - sop=1, eop=0: store to low half; in_pkt=1; go to HI.
  - sop=1, eop=1: emit a single-beat word. out_data={zeros, in_data}, sop=1, eop=1, out_empty=32+in_empty. Stay in LO.
  - sop=0, in_pkt=1, eop=0: store to low half (lo_sop=0); go to HI.
  - sop=0, in_pkt=1, eop=1: emit {zeros, in_data}, sop=0, eop=1, out_empty=32+in_empty; in_pkt=0.
  - sop=0, in_pkt=0: drop the beat and set proto_err.
- Accepted beat in HI:
  - sop=0: emit {in_data, lo_data}, out_sop=lo_sop, out_eop=in_eop, out_empty = in_eop ? in_empty : 0. If eop, in_pkt=0. Go to LO.
  - sop=1: discard the held half, set proto_err, and treat the beat as a fresh SOP from LO. Stay in HI, or emit a single-beat word if it also carries eop.
- Upper data bits of a half-empty EOP word are driven 0.
- out_empty arithmetic is 6-bit zero-extended; the maximum is 32+31=63.

## Timing
- Reset values: out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, proto_err=0, state=LO, in_pkt=0, rdy_en=0.
- in_ready=0 during reset and in the first clk edge after deassertion, because rdy_en is set on that edge.
- Latency: the output word is valid the cycle after the completing beat is accepted (second half, or an EOP first half).
- Throughput: one input beat per cycle sustained with out_ready=1. The output averages one word per two cycles, and one per cycle for back-to-back single-beat packets.
- Output fields hold stable while out_valid && !out_ready.
- If out_valid && out_ready and a completing beat are accepted in the same cycle, the register reloads with the new word and out_valid stays 1.
- Reset mid-packet: the held half and the pending output word are discarded with no partial emission after reset.

## Structure
- Shared package st_pkg: width constants (ST_W256=256, ST_W512=512, empty widths) and a typedef for the packed beat struct {data, sop, eop, empty}. The same package is shared with the 512→256 adapter.
- No sub-module is needed: one always_ff for the FSM/registers, plus combinational in_ready.

## Test plan
- Two-beat packet, A=0x11.., B=0x22.., eop on B with empty=4 -> one word {B,A}, sop=1, eop=1, out_empty=4.
- Three-beat packet, eop on beat 3 with empty=10 -> word1 {B,A} sop=1 eop=0; word2 {0,C} sop=0 eop=1 out_empty=42.
- Single-beat packets back-to-back with empty=0 -> one word per beat, each sop=eop=1, out_empty=32.
- out_ready=0 for 5 cycles mid-stream -> in_ready drops once the output is full, no beat is lost or duplicated, and the output is stable while stalled.
- sop arriving while a half is held -> held half dropped, proto_err=1 (sticky), new packet emitted intact; a non-SOP beat outside a packet is dropped.
- reset_n pulsed while in HI with out_valid=1 -> all outputs 0 and in_ready=0 during reset; in_ready=1 one cycle after release; the next packet packs correctly.

Source files
------------

// File: rtl/st_pkg.sv
`default_nettype none
// ============================================================================
// Module   : st_pkg
// Purpose  : Shared Avalon-ST widths, beat structs and gearbox state encoding
// Revision : 1.0
// ============================================================================
package st_pkg;

  localparam int ST_W256  = 256;
  localparam int ST_W512  = 512;
  localparam int ST_EW256 = 5;
  localparam int ST_EW512 = 6;

  typedef struct packed {
    logic [ST_W256-1:0]  data;
    logic                sop;
    logic                eop;
    logic [ST_EW256-1:0] empty;
  } st_beat256_t;

  typedef struct packed {
    logic [ST_W512-1:0]  data;
    logic                sop;
    logic                eop;
    logic [ST_EW512-1:0] empty;
  } st_beat512_t;

  typedef enum logic [0:0] {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } pk_state_t;

endpackage
`default_nettype wire

// File: rtl/st_packer_256_512.sv
`default_nettype none
// ============================================================================
// Module   : st_packer_256_512
// Purpose  : Packs pairs of 256-bit Avalon-ST beats into 512-bit words
// Revision : 1.0
// ============================================================================
module st_packer_256_512
  import st_pkg::*;
#(
  parameter int IN_W   = ST_W256,
  parameter int OUT_W  = ST_W512,
  parameter int IN_EW  = ST_EW256,
  parameter int OUT_EW = ST_EW512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_startofpacket,
  input  logic              in_endofpacket,
  input  logic [IN_EW-1:0]  in_empty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  output logic [OUT_EW-1:0] out_empty,
  output logic              proto_err
);

  localparam logic [OUT_EW-1:0] c_HALF_BYTES = OUT_EW'(IN_W / 8);

  pk_state_t         r_state;
  logic [IN_W-1:0]   r_lo_data;
  logic              r_lo_sop;
  logic              r_in_pkt;
  logic              r_rdy_en;

  logic              w_accept;
  logic [OUT_W-1:0]  w_single_data;
  logic [OUT_W-1:0]  w_pair_data;
  logic [OUT_EW-1:0] w_single_empty;
  logic [OUT_EW-1:0] w_pair_empty;

  // A beat is only taken when the output slot is free or draining this cycle.
  assign in_ready       = r_rdy_en && (!out_valid || out_ready);
  assign w_accept       = in_valid && in_ready;
  assign w_single_data  = {{(OUT_W-IN_W){1'b0}}, in_data};
  assign w_pair_data    = {in_data, r_lo_data};
  assign w_single_empty = c_HALF_BYTES + OUT_EW'(in_empty);
  assign w_pair_empty   = in_endofpacket ? OUT_EW'(in_empty) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= ST_LO;
      r_lo_data         <= '0;
      r_lo_sop          <= 1'b0;
      r_in_pkt          <= 1'b0;
      r_rdy_en          <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      proto_err         <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (in_startofpacket) begin
          // A SOP while a half is held abandons that half.
          if (r_state == ST_HI) begin
            proto_err <= 1'b1;
          end
          if (in_endofpacket) begin
            out_valid         <= 1'b1;
            out_data          <= w_single_data;
            out_startofpacket <= 1'b1;
            out_endofpacket   <= 1'b1;
            out_empty         <= w_single_empty;
            r_in_pkt          <= 1'b0;
            r_state           <= ST_LO;
          end else begin
            r_lo_data <= in_data;
            r_lo_sop  <= 1'b1;
            r_in_pkt  <= 1'b1;
            r_state   <= ST_HI;
          end
        end else if (r_state == ST_HI) begin
          out_valid         <= 1'b1;
          out_data          <= w_pair_data;
          out_startofpacket <= r_lo_sop;
          out_endofpacket   <= in_endofpacket;
          out_empty         <= w_pair_empty;
          if (in_endofpacket) begin
            r_in_pkt <= 1'b0;
          end
          r_state <= ST_LO;
        end else if (r_in_pkt) begin
          if (in_endofpacket) begin
            out_valid         <= 1'b1;
            out_data          <= w_single_data;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b1;
            out_empty         <= w_single_empty;
            r_in_pkt          <= 1'b0;
          end else begin
            r_lo_data <= in_data;
            r_lo_sop  <= 1'b0;
            r_state   <= ST_HI;
          end
        end else begin
          proto_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_st_packer_256_512.sv
`default_nettype none
// ============================================================================
// Module   : tb_st_packer_256_512
// Purpose  : Directed self-checking bench for the 256->512 Avalon-ST packer
// Revision : 1.0
// ============================================================================
module tb_st_packer_256_512;
  import st_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [ST_W256-1:0]  in_data = '0;
  logic                in_startofpacket = 1'b0;
  logic                in_endofpacket = 1'b0;
  logic [ST_EW256-1:0] in_empty = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [ST_W512-1:0]  out_data;
  logic                out_startofpacket;
  logic                out_endofpacket;
  logic [ST_EW512-1:0] out_empty;
  logic                proto_err;

  int total = 0;
  int bad   = 0;

  logic [ST_W256-1:0] c_a = {32{8'h11}};
  logic [ST_W256-1:0] c_b = {32{8'h22}};
  logic [ST_W256-1:0] c_c = {32{8'h33}};
  logic [ST_W256-1:0] c_d = {32{8'h44}};
  logic [ST_W256-1:0] c_e = {32{8'h55}};
  logic [ST_W256-1:0] c_f = {32{8'h66}};
  logic [ST_W256-1:0] c_z = '0;

  always #5 clk = ~clk;

  st_packer_256_512 dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .proto_err         (proto_err)
  );

  task automatic chk(input string tag, input logic [ST_W512-1:0] obs, input logic [ST_W512-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [ST_W512-1:0] data,
                          input logic sop, input logic eop, input logic [ST_EW512-1:0] empty);
    chk({tag, ".valid"}, ST_W512'(out_valid), ST_W512'(1'b1));
    chk({tag, ".data"},  out_data, data);
    chk({tag, ".sop"},   ST_W512'(out_startofpacket), ST_W512'(sop));
    chk({tag, ".eop"},   ST_W512'(out_endofpacket), ST_W512'(eop));
    chk({tag, ".empty"}, ST_W512'(out_empty), ST_W512'(empty));
  endtask

  // Presents a beat at a negedge and returns at the negedge after it is taken.
  task automatic send(input logic [ST_W256-1:0] d, input logic sop, input logic eop,
                      input logic [ST_EW256-1:0] emp);
    int guard;
    in_valid         = 1'b1;
    in_data          = d;
    in_startofpacket = sop;
    in_endofpacket   = eop;
    in_empty         = emp;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept");
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst.valid", ST_W512'(out_valid), '0);
    chk("rst.data", out_data, '0);
    chk("rst.empty", ST_W512'(out_empty), '0);
    chk("rst.err", ST_W512'(proto_err), '0);
    chk("rst.in_ready", ST_W512'(in_ready), '0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel.in_ready0", ST_W512'(in_ready), '0);
    @(negedge clk);
    chk("rel.in_ready1", ST_W512'(in_ready), ST_W512'(1'b1));

    // Two-beat packet
    send(c_a, 1'b1, 1'b0, 5'd0);
    chk("t1.halfvalid", ST_W512'(out_valid), '0);
    send(c_b, 1'b0, 1'b1, 5'd4);
    chk_word("t1", {c_b, c_a}, 1'b1, 1'b1, 6'd4);
    idle();
    chk("t1.drained", ST_W512'(out_valid), '0);

    // Three-beat packet
    send(c_a, 1'b1, 1'b0, 5'd0);
    send(c_b, 1'b0, 1'b0, 5'd0);
    chk_word("t2w1", {c_b, c_a}, 1'b1, 1'b0, 6'd0);
    send(c_c, 1'b0, 1'b1, 5'd10);
    chk_word("t2w2", {c_z, c_c}, 1'b0, 1'b1, 6'd42);
    idle();

    // Back-to-back single-beat packets
    send(c_d, 1'b1, 1'b1, 5'd0);
    chk_word("t3a", {c_z, c_d}, 1'b1, 1'b1, 6'd32);
    send(c_e, 1'b1, 1'b1, 5'd0);
    chk_word("t3b", {c_z, c_e}, 1'b1, 1'b1, 6'd32);
    send(c_f, 1'b1, 1'b1, 5'd31);
    chk_word("t3c", {c_z, c_f}, 1'b1, 1'b1, 6'd63);
    idle();

    // Output stall for 5 cycles
    send(c_a, 1'b1, 1'b0, 5'd0);
    out_ready = 1'b0;
    send(c_b, 1'b0, 1'b0, 5'd0);
    in_data          = c_c;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4.in_ready", ST_W512'(in_ready), '0);
      chk("t4.hold", out_data, {c_b, c_a});
      chk("t4.hold_valid", ST_W512'(out_valid), ST_W512'(1'b1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4.popped", ST_W512'(out_valid), '0);
    send(c_d, 1'b0, 1'b1, 5'd7);
    chk_word("t4w2", {c_d, c_c}, 1'b0, 1'b1, 6'd7);
    idle();
    chk("t4.no_dup", ST_W512'(out_valid), '0);
    chk("t4.err_clean", ST_W512'(proto_err), '0);

    // SOP while a half is held, then a stray non-SOP beat
    send(c_a, 1'b1, 1'b0, 5'd0);
    send(c_e, 1'b1, 1'b0, 5'd0);
    chk("t5.err", ST_W512'(proto_err), ST_W512'(1'b1));
    chk("t5.noemit", ST_W512'(out_valid), '0);
    send(c_f, 1'b0, 1'b1, 5'd8);
    chk_word("t5w", {c_f, c_e}, 1'b1, 1'b1, 6'd8);
    send(c_c, 1'b0, 1'b0, 5'd0);
    chk("t5.drop", ST_W512'(out_valid), '0);
    send(c_b, 1'b0, 1'b1, 5'd0);
    chk("t5.drop2", ST_W512'(out_valid), '0);
    send(c_d, 1'b1, 1'b1, 5'd3);
    chk_word("t5w2", {c_z, c_d}, 1'b1, 1'b1, 6'd35);
    idle();
    chk("t5.sticky", ST_W512'(proto_err), ST_W512'(1'b1));

    // Reset with a pending output word
    out_ready = 1'b0;
    send(c_e, 1'b1, 1'b1, 5'd1);
    chk("t6.pending", ST_W512'(out_valid), ST_W512'(1'b1));
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("t6.valid", ST_W512'(out_valid), '0);
    chk("t6.data", out_data, '0);
    chk("t6.sop", ST_W512'(out_startofpacket), '0);
    chk("t6.eop", ST_W512'(out_endofpacket), '0);
    chk("t6.empty", ST_W512'(out_empty), '0);
    chk("t6.err", ST_W512'(proto_err), '0);
    chk("t6.in_ready", ST_W512'(in_ready), '0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t6.rel0", ST_W512'(in_ready), '0);
    @(negedge clk);
    chk("t6.rel1", ST_W512'(in_ready), ST_W512'(1'b1));

    // Reset while a half is held
    send(c_a, 1'b1, 1'b0, 5'd0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t7.quiet", ST_W512'(out_valid), '0);
    send(c_c, 1'b1, 1'b0, 5'd0);
    send(c_d, 1'b0, 1'b1, 5'd0);
    chk_word("t7w", {c_d, c_c}, 1'b1, 1'b1, 6'd0);
    idle();
    chk("t7.err", ST_W512'(proto_err), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
